// File: rtl/sum_accumulator.sv
// Streaming packet accumulator built around a carry-lookahead adder.
// Optional feature: define ACC_SATURATE_EN to clamp the running total at all-ones on carry-out.

module sum_accumulator_cla #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  logic [DATA_WIDTH-1:0] prop;
  logic [DATA_WIDTH-1:0] gen;
  logic [DATA_WIDTH:0]   carry;

  // Flattened lookahead: carry into bit idx as a sum of generate terms over the propagate chain.
  function automatic logic carry_into(input logic [DATA_WIDTH-1:0] p,
                                      input logic [DATA_WIDTH-1:0] g,
                                      input logic                  c0,
                                      input int                    idx);
    logic c;
    logic prod;
    c    = 1'b0;
    prod = 1'b1;
    for (int j = idx - 1; j >= 0; j--) begin
      c    = c | (prod & g[j]);
      prod = prod & p[j];
    end
    return c | (prod & c0);
  endfunction

  assign prop = a ^ b;
  assign gen  = a & b;

  for (genvar i = 0; i <= DATA_WIDTH; i++) begin : g_carry
    assign carry[i] = carry_into(prop, gen, cin, i);
  end

  assign sum  = prop ^ carry[DATA_WIDTH-1:0];
  assign cout = carry[DATA_WIDTH];

endmodule

module sum_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_ovf,
  output logic [CNT_WIDTH-1:0]  out_count
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] acc;
  logic                  ovf;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] cla_sum;
  logic                  cla_cout;
  logic [DATA_WIDTH-1:0] acc_upd;
  logic                  ovf_upd;
  logic [CNT_WIDTH-1:0]  cnt_upd;
  logic                  beat;
  logic                  take;

  sum_accumulator_cla #(.DATA_WIDTH(DATA_WIDTH)) u_cla (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Handshake qualifiers, decoded from the state register so outputs stay input-independent.
  always_comb begin
    beat = 1'b0;
    take = 1'b0;
    if (state == ST_ACC) begin
      beat = in_valid;
    end else begin
      take = out_ready;
    end
  end

  // Candidate accumulator values for an accepted beat.
  always_comb begin
    acc_upd = cla_sum;
`ifdef ACC_SATURATE_EN
    if (cla_cout) begin
      acc_upd = {DATA_WIDTH{1'b1}};
    end else begin
      acc_upd = cla_sum;
    end
`endif
    ovf_upd = ovf | cla_cout;
    if (cnt == {CNT_WIDTH{1'b1}}) begin
      cnt_upd = cnt;
    end else begin
      cnt_upd = cnt + CNT_WIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC: begin
        if (beat && in_last) begin
          state_next = ST_OUT;
        end else begin
          state_next = ST_ACC;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_next = ST_ACC;
        end else begin
          state_next = ST_OUT;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  // Stream control outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_OUT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Running total and result registers; the final beat lands in both in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= {DATA_WIDTH{1'b0}};
      ovf       <= 1'b0;
      cnt       <= {CNT_WIDTH{1'b0}};
      out_sum   <= {DATA_WIDTH{1'b0}};
      out_ovf   <= 1'b0;
      out_count <= {CNT_WIDTH{1'b0}};
    end else if (beat) begin
      acc <= acc_upd;
      ovf <= ovf_upd;
      cnt <= cnt_upd;
      if (in_last) begin
        out_sum   <= acc_upd;
        out_ovf   <= ovf_upd;
        out_count <= cnt_upd;
      end
    end else if (take) begin
      acc <= {DATA_WIDTH{1'b0}};
      ovf <= 1'b0;
      cnt <= {CNT_WIDTH{1'b0}};
    end
  end

endmodule
